sram_mem_ctrl: RTL and testbench

- Parametrised successor to the MEM-stage SRAM controller.
- Serialises a DATA_W-bit pipeline load/store into BEATS = DATA_W/16 accesses on the 16-bit external SRAM.
- Adds three features: programmable wait states per beat, per-byte write enables, and the base-address remap folded into the block.
- Sits in the MEM stage. It stalls the pipeline through ready until the access completes.

---
 rtl/sram_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage load/store serialiser for a 16-bit asynchronous SRAM.
// A DATA_W access becomes DATA_W/16 little-endian beats of WAIT_CYCLES+1 cycles each.
//
// state  | meaning
// IDLE   | no access; ready follows ~(rd_en|wr_en), request latched on the edge
// ACCESS | beats driven on the SRAM, pipeline frozen
// DONE   | access complete, ready high for one cycle, readData valid
module sram_mem_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      writeData,
  input  logic [DATA_W/8-1:0]    byte_en,
  output logic [DATA_W-1:0]      readData,
  output logic                   ready,
  inout  wire  [15:0]            SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);
  localparam int BEATS   = DATA_W / 16;
  localparam int BE_W    = DATA_W / 8;
  localparam int OFS_SH  = $clog2(BE_W);
  localparam int BEAT_SH = $clog2(BEATS);
  localparam int BEAT_W  = (BEATS > 1) ? BEAT_SH : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic              op_wr;
  logic [31:0]       word;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] shadow_nxt;
  logic [BEAT_W-1:0] beat;
  logic [2:0]        wait_cnt;
  logic              req;
  logic              beat_end;
  logic              last_beat;
  logic [31:0]       beat_addr;
  logic [15:0]       beat_data;
  logic [1:0]        beat_be;
  logic              dq_oe;

  assign req       = wr_en | rd_en;
  assign beat_end  = (wait_cnt == 3'd0);
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign beat_addr = (word << BEAT_SH) + 32'(beat);
  assign SRAM_DQ   = dq_oe ? beat_data : 16'hzzzz;

  // Per-beat slice of the latched store data/enables and the read shadow slot
  always_comb begin
    beat_data  = 16'h0000;
    beat_be    = 2'b00;
    shadow_nxt = shadow;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        beat_data              = wdata_q[16*b +: 16];
        beat_be                = be_q[2*b +: 2];
        shadow_nxt[16*b +: 16] = SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    SRAM_ADDR = '0;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        ready     = 1'b0;
        SRAM_CE_N = 1'b0;
        SRAM_ADDR = beat_addr[SRAM_ADDR_W-1:0];
        if (op_wr) begin
          dq_oe     = 1'b1;
          SRAM_UB_N = ~beat_be[1];
          SRAM_LB_N = ~beat_be[0];
          // Strobe low during the wait cycles, released on the beat's last cycle
          if (beat_be != 2'b00) SRAM_WE_N = (WAIT_CYCLES == 0) ? 1'b0 : beat_end;
        end else begin
          SRAM_OE_N = 1'b0;
          SRAM_UB_N = 1'b0;
          SRAM_LB_N = 1'b0;
        end
        if (beat_end && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) ready = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      word     <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      shadow   <= '0;
      readData <= '0;
      beat     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= wr_en;
            word     <= (address - BASE_ADDR) >> OFS_SH;
            wdata_q  <= writeData;
            be_q     <= byte_en;
            beat     <= '0;
            wait_cnt <= 3'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (beat_end) begin
            wait_cnt <= 3'(WAIT_CYCLES);
            beat     <= beat + 1'b1;
            if (!op_wr) begin
              shadow <= shadow_nxt;
              if (last_beat) readData <= shadow_nxt;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: three controller configurations (32/W1, 64/W0, 16/W3) driven in
// lockstep against behavioural SRAMs and an array-based reference of the memory image.
module tb_sram_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address;
  logic [63:0] wdata;
  logic [7:0]  bmask;

  logic [31:0] rdata32;  logic [63:0] rdata64;  logic [15:0] rdata16;
  logic        ready32, ready64, ready16;
  wire  [15:0] dq32, dq64, dq16;
  logic [17:0] addr32;   logic [11:0] addr64;   logic [11:0] addr16;
  logic ub32, lb32, we32, ce32, oe32;
  logic ub64, lb64, we64, ce64, oe64;
  logic ub16, lb16, we16, ce16, oe16;

  logic [15:0] mem32 [0:262143];
  logic [15:0] mem64 [0:4095];
  logic [15:0] mem16 [0:4095];
  logic [15:0] ref_mem [int];
  logic [63:0] exp_rd [3];

  int tests = 0;
  int fails = 0;
  int lows [3];
  int we_low [3];
  logic [17:0] addr_q [$];
  logic we_q [$];
  logic ub_q [$];
  logic lb_q [$];

  always #5 clk = ~clk;

  sram_mem_ctrl #(.DATA_W(32), .SRAM_ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(wdata[31:0]), .byte_en(bmask[3:0]), .readData(rdata32), .ready(ready32),
    .SRAM_DQ(dq32), .SRAM_ADDR(addr32), .SRAM_UB_N(ub32), .SRAM_LB_N(lb32),
    .SRAM_WE_N(we32), .SRAM_CE_N(ce32), .SRAM_OE_N(oe32));

  sram_mem_ctrl #(.DATA_W(64), .SRAM_ADDR_W(12), .WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u64 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(wdata), .byte_en(bmask), .readData(rdata64), .ready(ready64),
    .SRAM_DQ(dq64), .SRAM_ADDR(addr64), .SRAM_UB_N(ub64), .SRAM_LB_N(lb64),
    .SRAM_WE_N(we64), .SRAM_CE_N(ce64), .SRAM_OE_N(oe64));

  sram_mem_ctrl #(.DATA_W(16), .SRAM_ADDR_W(12), .WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) u16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(wdata[15:0]), .byte_en(bmask[1:0]), .readData(rdata16), .ready(ready16),
    .SRAM_DQ(dq16), .SRAM_ADDR(addr16), .SRAM_UB_N(ub16), .SRAM_LB_N(lb16),
    .SRAM_WE_N(we16), .SRAM_CE_N(ce16), .SRAM_OE_N(oe16));

  // Behavioural asynchronous SRAMs, writes taken on the clock while WE_N is low
  assign dq32 = (!ce32 && !oe32 && we32) ? mem32[addr32] : 16'hzzzz;
  assign dq64 = (!ce64 && !oe64 && we64) ? mem64[addr64] : 16'hzzzz;
  assign dq16 = (!ce16 && !oe16 && we16) ? mem16[addr16] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce32 && !we32) begin
      if (!lb32) mem32[addr32][7:0]  <= dq32[7:0];
      if (!ub32) mem32[addr32][15:8] <= dq32[15:8];
    end
    if (!ce64 && !we64) begin
      if (!lb64) mem64[addr64][7:0]  <= dq64[7:0];
      if (!ub64) mem64[addr64][15:8] <= dq64[15:8];
    end
    if (!ce16 && !we16) begin
      if (!lb16) mem16[addr16][7:0]  <= dq16[7:0];
      if (!ub16) mem16[addr16][15:8] <= dq16[15:8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rget(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
  endfunction

  function automatic logic [15:0] sram_get(input int inst, input int idx);
    case (inst)
      0:       return mem32[idx];
      1:       return mem64[idx];
      default: return mem16[idx];
    endcase
  endfunction

  task automatic poke(input int inst, input int idx, input logic [15:0] v);
    case (inst)
      0:       mem32[idx] = v;
      1:       mem64[idx] = v;
      default: mem16[idx] = v;
    endcase
    ref_mem[inst * (1 << 20) + idx] = v;
  endtask

  // Reference: memory as an array of 16-bit words, access = consecutive little-endian words
  task automatic model(input int inst, input bit wr, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] bm, output logic [63:0] rd);
    int beats = (inst == 0) ? 2 : (inst == 1) ? 4 : 1;
    int aw    = (inst == 0) ? 18 : 12;
    logic [31:0] word, idx, mask;
    logic [15:0] cur;
    int key;
    mask = (32'd1 << aw) - 32'd1;
    word = (a - 32'd1024) / (beats * 2);
    rd = '0;
    for (int b = 0; b < beats; b++) begin
      idx = (word * beats + b) & mask;
      key = inst * (1 << 20) + int'(idx);
      if (wr) begin
        cur = rget(key);
        for (int j = 0; j < 2; j++)
          if (bm[2*b+j]) cur[8*j +: 8] = d[16*b + 8*j +: 8];
        ref_mem[key] = cur;
      end else begin
        rd[16*b +: 16] = rget(key);
      end
    end
  endtask

  task automatic run_dut(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] bm);
    int n = 0;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; wdata = d; bmask = bm;
    for (int i = 0; i < 3; i++) begin lows[i] = 0; we_low[i] = 0; end
    addr_q.delete(); we_q.delete(); ub_q.delete(); lb_q.delete();
    #1;
    while (!(ready32 && ready64 && ready16) && n < 40) begin
      lows[0] += int'(!ready32); lows[1] += int'(!ready64); lows[2] += int'(!ready16);
      if (n > 0) begin
        addr_q.push_back(addr32); we_q.push_back(we32); ub_q.push_back(ub32); lb_q.push_back(lb32);
        we_low[0] += int'(!we32); we_low[1] += int'(!we64); we_low[2] += int'(!we16);
      end
      n++;
      @(negedge clk);
      if (n == 1) begin
        address = $urandom; wdata = {$urandom, $urandom}; bmask = 8'($urandom);
      end
      #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] bm);
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      model(i, wr, a, d, bm, r);
      if (!wr) exp_rd[i] = r;
    end
    run_dut(wr, rd, a, d, bm);
    check({tag, "_lat32"}, 64'(lows[0]), 64'd5);
    check({tag, "_lat64"}, 64'(lows[1]), 64'd5);
    check({tag, "_lat16"}, 64'(lows[2]), 64'd5);
    check({tag, "_rd32"}, 64'(rdata32), exp_rd[0] & 64'hFFFF_FFFF);
    check({tag, "_rd64"}, rdata64, exp_rd[1]);
    check({tag, "_rd16"}, 64'(rdata16), exp_rd[2] & 64'hFFFF);
  endtask

  initial begin
    int mism;
    int sel;
    logic [31:0] a;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032; wdata = '0; bmask = '0;
    for (int i = 0; i < 3; i++) exp_rd[i] = '0;
    for (int i = 0; i < 262144; i++) mem32[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) begin mem64[i] = 16'h0000; mem16[i] = 16'h0000; end
    #3;
    check("rst_ready", 64'(ready32), 64'd1);
    check("rst_rdata", 64'(rdata32), 64'd0);
    check("rst_ctl32", 64'({ub32, lb32, we32, ce32, oe32}), 64'h1F);
    check("rst_addr32", 64'(addr32), 64'd0);
    rd_en = 1'b0;
    @(negedge clk); rst = 1'b0;

    for (int inst = 0; inst < 3; inst++)
      for (int i = 0; i < 128; i++) poke(inst, i, 16'($urandom));
    poke(0, 4, 16'hBEEF); poke(0, 5, 16'hDEAD);

    do_op("rd1032", 1'b0, 1'b1, 32'd1032, 64'd0, 8'h00);
    check("rd_beef", 64'(rdata32), 64'h0000_0000_DEAD_BEEF);
    check("rd_addr0", 64'(addr_q[0]), 64'd4);
    check("rd_addr1", 64'(addr_q[1]), 64'd4);
    check("rd_addr2", 64'(addr_q[2]), 64'd5);
    check("rd_addr3", 64'(addr_q[3]), 64'd5);
    check("done_ctl32", 64'({ub32, lb32, we32, ce32, oe32}), 64'h1F);

    do_op("wr1024", 1'b1, 1'b0, 32'd1024, {32'hCAFEF00D, 32'h12345678}, 8'hFF);
    check("wr_mem0", 64'(mem32[0]), 64'h5678);
    check("wr_mem1", 64'(mem32[1]), 64'h1234);
    check("wr_welow32", 64'(we_low[0]), 64'd2);
    check("wr_welow64", 64'(we_low[1]), 64'd4);
    check("wr_welow16", 64'(we_low[2]), 64'd3);

    poke(0, 2, 16'h1111); poke(0, 3, 16'h2222);
    do_op("wrbe", 1'b1, 1'b0, 32'd1028, {32'h0, 32'hAABBCCDD}, 8'b0000_0100);
    check("be_mem2", 64'(mem32[2]), 64'h1111);
    check("be_mem3", 64'(mem32[3]), 64'h22BB);
    check("be_we_b0c0", 64'(we_q[0]), 64'd1);
    check("be_we_b0c1", 64'(we_q[1]), 64'd1);
    check("be_ub_b1", 64'(ub_q[2]), 64'd1);
    check("be_lb_b1", 64'(lb_q[2]), 64'd0);
    check("be_welow32", 64'(we_low[0]), 64'd1);
    check("be_welow64", 64'(we_low[1]), 64'd1);
    check("be_welow16", 64'(we_low[2]), 64'd0);

    do_op("rdwr", 1'b1, 1'b1, 32'd1040, {$urandom, $urandom}, 8'hFF);
    check("rdwr_keep", 64'(rdata32), 64'h0000_0000_DEAD_BEEF);

    do_op("wrap_wr", 1'b1, 1'b0, 32'd1020, {32'h0BAD_F00D, 32'h5555_AAAA}, 8'hFF);
    check("wrap_a0", 64'(addr_q[0]), 64'h3FFFE);
    check("wrap_a1", 64'(addr_q[1]), 64'h3FFFE);
    check("wrap_a2", 64'(addr_q[2]), 64'h3FFFF);
    check("wrap_a3", 64'(addr_q[3]), 64'h3FFFF);
    do_op("wrap_rd", 1'b0, 1'b1, 32'd1020, 64'd0, 8'h00);

    // Abort a write in its third ACCESS cycle; its target region is never read back
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1536; wdata = {$urandom, $urandom}; bmask = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("abort_ctl32", 64'({ub32, lb32, we32, ce32, oe32}), 64'h1F);
    check("abort_ctl64", 64'({ub64, lb64, we64, ce64, oe64}), 64'h1F);
    check("abort_ctl16", 64'({ub16, lb16, we16, ce16, oe16}), 64'h1F);
    check("abort_ready", 64'({ready32, ready64, ready16}), 64'h7);
    check("abort_rd32", 64'(rdata32), 64'd0);
    check("abort_rd64", rdata64, 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_rd[i] = '0;
    do_op("post_rst", 1'b0, 1'b1, 32'd1032, 64'd0, 8'h00);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      a = 32'd1024 + 32'($urandom_range(0, 255));
      do_op("rand", (sel < 2) || (sel == 3), sel >= 2, a, {$urandom, $urandom}, 8'($urandom));
    end

    for (int inst = 0; inst < 3; inst++) begin
      mism = 0;
      for (int i = 0; i < 128; i++)
        if (sram_get(inst, i) !== rget(inst * (1 << 20) + i)) mism++;
      check($sformatf("mem_image%0d", inst), 64'(mism), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
